// File: rtl/uart_write_arbiter.sv
// uart_write_arbiter: round-robin write lock for compute threads, with a
// shared byte FIFO draining to the UART transmitter.
module uart_write_arbiter #(
  parameter int NTHREADS   = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int CNTW       = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NTHREADS-1:0]   write_lock_req,
  output logic [NTHREADS-1:0]   write_lock_res,
  output logic [NTHREADS-1:0]   write_ready,
  input  logic [8*NTHREADS-1:0] write_data,
  input  logic [NTHREADS-1:0]   write_data_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  overflow,
  output logic                  busy
);

  localparam int IDXW = (NTHREADS > 1) ? $clog2(NTHREADS) : 1;
  localparam int PTRW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANTED, ARB_RELEASE} arb_state_t;

  arb_state_t          state_reg, state_next;
  logic [IDXW-1:0]     grant_reg, grant_next;
  logic [IDXW-1:0]     rr_reg, rr_next;
  logic [IDXW-1:0]     pick_idx;
  logic                pick_found;
  logic [NTHREADS-1:0] res_reg, res_next;
  logic [NTHREADS-1:0] ready_reg, ready_next;

  logic [7:0]          mem [FIFO_DEPTH];
  logic [PTRW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [CNTW-1:0]     count_reg, count_next;
  logic                overflow_reg;

  logic                fifo_full, push_attempt, push, pop;
  logic [7:0]          thread_byte [NTHREADS];
  logic [7:0]          grant_byte;

  // Split the packed thread data bus into one byte per thread.
  genvar gi;
  generate
    for (gi = 0; gi < NTHREADS; gi++) begin : g_thread_byte
      assign thread_byte[gi] = write_data[8*gi +: 8];
    end
  endgenerate

  assign grant_byte   = thread_byte[grant_reg];
  assign fifo_full    = (count_reg == CNTW'(FIFO_DEPTH));
  assign tx_valid     = (count_reg != '0);
  assign tx_data      = mem[rd_ptr_reg];
  assign pop          = tx_valid && tx_ready;
  // Only the lock holder can push; a concurrent pop frees the slot for it.
  assign push_attempt = (state_reg == ARB_GRANTED) && write_data_valid[grant_reg];
  assign push         = push_attempt && (!fifo_full || pop);

  assign write_lock_res = res_reg;
  assign write_ready    = ready_reg;
  assign overflow       = overflow_reg;
  assign busy           = (state_reg != ARB_IDLE) || tx_valid;

  // Round-robin pick: first requester at or above rr, wrapping around.
  always_comb begin
    int              cand;
    logic [IDXW-1:0] cand_idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 0; k < NTHREADS; k++) begin
      cand = int'(rr_reg) + k;
      if (cand >= NTHREADS) cand = cand - NTHREADS;
      cand_idx = cand[IDXW-1:0];
      if (!pick_found && write_lock_req[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Arbiter next-state: grant, hold while requested, one dead cycle on release.
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    rr_next    = rr_reg;
    res_next   = res_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_next         = pick_idx;
          res_next           = '0;
          res_next[pick_idx] = 1'b1;
          state_next         = ARB_GRANTED;
        end
      end
      ARB_GRANTED: begin
        if (!write_lock_req[grant_reg]) begin
          res_next   = '0;
          rr_next    = (int'(grant_reg) == NTHREADS - 1) ? '0 : grant_reg + IDXW'(1);
          state_next = ARB_RELEASE;
        end
      end
      ARB_RELEASE: begin
        res_next   = '0;
        state_next = ARB_IDLE;
      end
      default: begin
        res_next   = '0;
        state_next = ARB_IDLE;
      end
    endcase
  end

  // FIFO occupancy after this cycle's push and pop.
  always_comb begin
    count_next = count_reg;
    if (push && !pop)      count_next = count_reg + CNTW'(1);
    else if (!push && pop) count_next = count_reg - CNTW'(1);
  end

  // Ready needs two free slots: one for the byte already in flight from the thread.
  always_comb begin
    ready_next = '0;
    if ((state_reg == ARB_GRANTED) && write_lock_req[grant_reg] &&
        (count_next <= CNTW'(FIFO_DEPTH - 2)))
      ready_next[grant_reg] = 1'b1;
  end

  // Arbiter, FIFO pointer and status registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ARB_IDLE;
      grant_reg    <= '0;
      rr_reg       <= '0;
      res_reg      <= '0;
      ready_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      rr_reg     <= rr_next;
      res_reg    <= res_next;
      ready_reg  <= ready_next;
      count_reg  <= count_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTRW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTRW'(1);
      if (push_attempt && !push) overflow_reg <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset since count gates visibility.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_reg] <= grant_byte;
  end

endmodule

// File: tb/tb_uart_write_arbiter.sv
// Directed bench for uart_write_arbiter (NTHREADS=2, FIFO_DEPTH=16).
module tb_uart_write_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  write_lock_req;
  logic [1:0]  write_lock_res;
  logic [1:0]  write_ready;
  logic [15:0] write_data;
  logic [1:0]  write_data_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        overflow;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  uart_write_arbiter #(
    .NTHREADS(2),
    .FIFO_DEPTH(16),
    .CNTW(5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .write_lock_req(write_lock_req),
    .write_lock_res(write_lock_res),
    .write_ready(write_ready),
    .write_data(write_data),
    .write_data_valid(write_data_valid),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .overflow(overflow),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Capture every byte the UART accepts (pop happens at the following posedge).
  always @(negedge clock) begin
    if (!reset && tx_valid && tx_ready) rx_q.push_back(tx_data);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    write_lock_req   = '0;
    write_data       = '0;
    write_data_valid = '0;
    tx_ready         = 1'b0;
    step();
    step();
    reset = 1'b0;
    rx_q.delete();
    exp_q.delete();
  endtask

  // Send src_q on thread t, offering a byte only in cycles where ready was seen high.
  task automatic stream(input int t);
    int sent;
    int n;
    sent = 0;
    n    = src_q.size();
    for (int cyc = 0; cyc < 300 && sent < n; cyc++) begin
      if (write_ready[t]) begin
        write_data_valid[t]  = 1'b1;
        write_data[8*t +: 8] = src_q[sent];
        exp_q.push_back(src_q[sent]);
        sent++;
      end else begin
        write_data_valid[t] = 1'b0;
      end
      step();
    end
    write_data_valid = '0;
    chk("stream_sent", sent, n);
    src_q.delete();
  endtask

  task automatic drain();
    write_lock_req = '0;
    tx_ready       = 1'b1;
    for (int c = 0; c < 200 && busy; c++) step();
    chk("drain_idle", {31'd0, busy}, 0);
  endtask

  task automatic check_rx();
    int n;
    chk("rx_len", rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("rx_byte%0d", i), rx_q[i], exp_q[i]);
  endtask

  initial begin
    do_reset();
    chk("rst_res", write_lock_res, 2'b00);
    chk("rst_ready", write_ready, 2'b00);
    chk("rst_txvalid", tx_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);

    // Single thread, 5-byte message.
    tx_ready       = 1'b1;
    write_lock_req = 2'b01;
    step();
    chk("t1_res", write_lock_res, 2'b01);
    src_q = '{8'h0D, 8'h00, 8'h00, 8'h00, 8'hA5};
    stream(0);
    drain();
    chk("t1_overflow", overflow, 0);
    check_rx();

    // Contention: thread 0 wins, thread 1 follows after the release gap.
    do_reset();
    write_lock_req = 2'b11;
    step();
    chk("t2_res0", write_lock_res, 2'b01);
    write_data[15:8]    = 8'hEE;
    write_data_valid[1] = 1'b1;
    src_q = '{8'h10, 8'h11, 8'h12};
    stream(0);
    write_lock_req = 2'b10;
    step();
    chk("t2_res_drop", write_lock_res, 2'b00);
    step();
    chk("t2_res_idle", write_lock_res, 2'b00);
    step();
    chk("t2_res1", write_lock_res, 2'b10);
    src_q = '{8'h20, 8'h21, 8'h22};
    stream(1);
    drain();
    check_rx();

    // Backpressure: a ready-following thread tops out at 15 bytes, no drop.
    do_reset();
    write_lock_req = 2'b01;
    step();
    for (int i = 0; i < 15; i++) src_q.push_back(8'h30 + 8'(i));
    stream(0);
    step();
    step();
    chk("t3_ready_low", write_ready, 2'b00);
    chk("t3_txvalid", tx_valid, 1);
    chk("t3_overflow", overflow, 0);
    drain();
    check_rx();

    // Overflow: valid forced for 17 cycles, the 17th byte is lost.
    do_reset();
    write_lock_req = 2'b01;
    step();
    for (int i = 0; i < 17; i++) begin
      write_data_valid[0] = 1'b1;
      write_data[7:0]     = 8'h40 + 8'(i);
      if (i < 16) exp_q.push_back(8'h40 + 8'(i));
      step();
      if (i == 15) chk("t4_ovf_at16", overflow, 0);
      if (i == 16) chk("t4_ovf_at17", overflow, 1);
    end
    write_data_valid = '0;
    drain();
    chk("t4_ovf_sticky", overflow, 1);
    check_rx();

    // Full FIFO with simultaneous push and pop.
    do_reset();
    write_lock_req = 2'b01;
    step();
    for (int i = 0; i < 16; i++) begin
      write_data_valid[0] = 1'b1;
      write_data[7:0]     = 8'h50 + 8'(i);
      exp_q.push_back(8'h50 + 8'(i));
      step();
    end
    chk("t5_full_ovf", overflow, 0);
    chk("t5_full_ready", write_ready, 2'b00);
    tx_ready        = 1'b1;
    write_data[7:0] = 8'h60;
    exp_q.push_back(8'h60);
    step();
    chk("t5_pushpop_ovf", overflow, 0);
    // Still full afterwards: a lone push must now be dropped.
    tx_ready        = 1'b0;
    write_data[7:0] = 8'h61;
    step();
    chk("t5_still_full", overflow, 1);
    write_data_valid = '0;
    drain();
    check_rx();

    // Reset mid-transfer with thread 1 holding the lock.
    do_reset();
    write_lock_req = 2'b10;
    step();
    chk("t6_res1", write_lock_res, 2'b10);
    for (int i = 0; i < 6; i++) src_q.push_back(8'h70 + 8'(i));
    stream(1);
    chk("t6_queued", tx_valid, 1);
    reset = 1'b1;
    step();
    chk("t6_rst_res", write_lock_res, 2'b00);
    chk("t6_rst_ready", write_ready, 2'b00);
    chk("t6_rst_txvalid", tx_valid, 0);
    chk("t6_rst_overflow", overflow, 0);
    chk("t6_rst_busy", busy, 0);
    reset          = 1'b0;
    write_lock_req = 2'b11;
    step();
    chk("t6_rr_reset", write_lock_res, 2'b01);
    chk("t6_rx_empty", rx_q.size(), 0);
    write_lock_req = '0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
